// File: rtl/control_pkg.sv
// control_pkg -- shared definitions for the multicycle control unit.
//   state_e    : FSM states, one per instruction phase
//   class_e    : decoded instruction class
//   OP_*       : opcode values (zero-extended to the opcode width at use)
//   ALU_*      : fixed aluOp codes for address and compare arithmetic
//   Y_*        : bit positions inside the control word
//                y = {regDst, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite}
package control_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_NOP,
    CL_LOAD,
    CL_STORE,
    CL_BEQ
  } class_e;

  localparam int OP_RTYPE = 'h01;
  localparam int OP_NOP   = 'h02;
  localparam int OP_LOAD  = 'h10;
  localparam int OP_STORE = 'h11;
  localparam int OP_BEQ   = 'h20;

  localparam int ALU_ADD = 1;
  localparam int ALU_SUB = 2;

  // Fields below aluOp have fixed positions.
  localparam int Y_REG_WRITE  = 0;
  localparam int Y_ALU_SRC    = 1;
  localparam int Y_MEM_WRITE  = 2;
  localparam int Y_ALU_OP_LSB = 3;

  // Fields above aluOp move with its width, so they are offsets from
  // the first bit past aluOp.
  localparam int Y_MEM_TO_REG_OFS = 0;
  localparam int Y_MEM_READ_OFS   = 1;
  localparam int Y_BRANCH_OFS     = 2;
  localparam int Y_REG_DST_OFS    = 3;

endpackage

// File: rtl/control_decode.sv
// control_decode -- combinational instruction-register decoder.
//   ir         in  : latched opcode
//   legal      out : opcode is one of the supported instructions
//   op_class   out : instruction class (meaningful only when legal)
//   alu_op     out : aluOp used during EXECUTE
//   reg_dst    out : destination register comes from the rd field (R-type)
//   mem_to_reg out : writeback data comes from memory (LOAD)
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 8
) (
  input  logic [OPCODE_W-1:0] ir,
  output logic                legal,
  output class_e              op_class,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg
);

  always_comb begin
    legal      = 1'b1;
    op_class   = CL_NOP;
    alu_op     = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    if (ir == OPCODE_W'(OP_RTYPE)) begin
      op_class = CL_RTYPE;
      // R-type passes the instruction word straight through as the ALU function.
      alu_op   = ALUOP_W'(ir);
      reg_dst  = 1'b1;
    end else if (ir == OPCODE_W'(OP_NOP)) begin
      op_class = CL_NOP;
    end else if (ir == OPCODE_W'(OP_LOAD)) begin
      op_class   = CL_LOAD;
      alu_op     = ALUOP_W'(ALU_ADD);
      mem_to_reg = 1'b1;
    end else if (ir == OPCODE_W'(OP_STORE)) begin
      op_class = CL_STORE;
      alu_op   = ALUOP_W'(ALU_ADD);
    end else if (ir == OPCODE_W'(OP_BEQ)) begin
      op_class = CL_BEQ;
      alu_op   = ALUOP_W'(ALU_SUB);
    end else begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control -- FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   opcode       : instruction memory data, captured in FETCH when imem_ready
//   imem_ready   : instruction memory data valid
//   dmem_ready   : data memory access complete
//   imem_req     : instruction fetch request (FETCH)
//   dmem_req     : data memory request (MEM)
//   ir_write     : latch the instruction register
//   pc_write     : advance the PC, one pulse per retired instruction
//   illegal_op   : one-cycle pulse when the latched opcode is undecodable
//   y            : {regDst, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite}
//   instr_count  : retired instructions, saturating
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                illegal_op,
  output logic [ALUOP_W+6:0]  y,
  output logic [COUNT_W-1:0]  instr_count
);

  localparam int Y_HI = Y_ALU_OP_LSB + ALUOP_W;

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   ir_q, ir_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  logic                  dec_legal;
  class_e                dec_class;
  logic [ALUOP_W-1:0]    dec_alu_op;
  logic                  dec_reg_dst;
  logic                  dec_mem_to_reg;

  logic                  reg_dst, branch, mem_read, mem_to_reg;
  logic                  mem_write, alu_src, reg_write;
  logic [ALUOP_W-1:0]    alu_op;

  control_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .ir         (ir_q),
    .legal      (dec_legal),
    .op_class   (dec_class),
    .alu_op     (dec_alu_op),
    .reg_dst    (dec_reg_dst),
    .mem_to_reg (dec_mem_to_reg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    illegal_op = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = '0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          ir_d     = opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end else if (dec_class == CL_NOP) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = dec_alu_op;
        case (dec_class)
          CL_RTYPE: state_d = S_WB;
          CL_LOAD, CL_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CL_BEQ: begin
            // The PC mux qualifies this with the ALU zero flag; the
            // instruction retires either way.
            branch   = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_W'(ALU_ADD);
        mem_read  = (dec_class == CL_LOAD);
        mem_write = (dec_class == CL_STORE);
        if (dmem_ready) begin
          if (dec_class == CL_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = dec_reg_dst;
        mem_to_reg = dec_mem_to_reg;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Counter tracks pc_write exactly and sticks at all-ones.
    count_d = count_q;
    if (pc_write && (count_q != '1)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    y                                   = '0;
    y[Y_REG_WRITE]                      = reg_write;
    y[Y_ALU_SRC]                        = alu_src;
    y[Y_MEM_WRITE]                      = mem_write;
    y[Y_ALU_OP_LSB +: ALUOP_W]          = alu_op;
    y[Y_HI + Y_MEM_TO_REG_OFS]          = mem_to_reg;
    y[Y_HI + Y_MEM_READ_OFS]            = mem_read;
    y[Y_HI + Y_BRANCH_OFS]              = branch;
    y[Y_HI + Y_REG_DST_OFS]             = reg_dst;
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- directed vector table, hand-written reset/saturation
// sequences and a randomized run against a step-list reference model.
// A second instance with a 2-bit counter exercises saturation alongside.
module tb_multicycle_control;

  localparam int OPCODE_W = 8;
  localparam int ALUOP_W  = 8;
  localparam int Y_W      = ALUOP_W + 7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [OPCODE_W-1:0] opcode;
  logic                imem_ready, dmem_ready;

  logic                imem_req, dmem_req, ir_write, pc_write, illegal_op;
  logic [Y_W-1:0]      y;
  logic [15:0]         instr_count;

  logic                s_imem_req, s_dmem_req, s_ir_write, s_pc_write, s_illegal_op;
  logic [Y_W-1:0]      s_y;
  logic [1:0]          s_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(8), .ALUOP_W(8), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .ir_write(ir_write), .pc_write(pc_write), .illegal_op(illegal_op),
    .y(y), .instr_count(instr_count)
  );

  multicycle_control #(.OPCODE_W(8), .ALUOP_W(8), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(s_imem_req), .dmem_req(s_dmem_req),
    .ir_write(s_ir_write), .pc_write(s_pc_write), .illegal_op(s_illegal_op),
    .y(s_y), .instr_count(s_count)
  );

  typedef struct {
    logic [7:0]     op;
    logic           ir_rdy;
    logic           dm_rdy;
    logic           e_ireq;
    logic           e_dreq;
    logic           e_irw;
    logic           e_pcw;
    logic           e_ill;
    logic [Y_W-1:0] e_y;
    int             e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic ir_rdy, input logic dm_rdy,
                              input logic ireq, input logic dreq, input logic irw,
                              input logic pcw, input logic ill, input logic [Y_W-1:0] ey,
                              input int cnt);
    vec_t v;
    v.op = op; v.ir_rdy = ir_rdy; v.dm_rdy = dm_rdy;
    v.e_ireq = ireq; v.e_dreq = dreq; v.e_irw = irw; v.e_pcw = pcw; v.e_ill = ill;
    v.e_y = ey; v.e_cnt = cnt;
    return v;
  endfunction

  // Control word packing: {regDst, branch, memRead, memToReg, aluOp, memWrite, aluSrc, regWrite}
  function automatic logic [Y_W-1:0] mky(input logic rd, input logic br, input logic mr,
                                         input logic m2r, input logic [7:0] aop,
                                         input logic mw, input logic as_, input logic rw);
    return {rd, br, mr, m2r, aop, mw, as_, rw};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ireq, input logic e_dreq,
                           input logic e_irw, input logic e_pcw, input logic e_ill,
                           input logic [Y_W-1:0] e_y, input int e_cnt);
    chk({tag, ".imem_req"},   32'(imem_req),    32'(e_ireq));
    chk({tag, ".dmem_req"},   32'(dmem_req),    32'(e_dreq));
    chk({tag, ".ir_write"},   32'(ir_write),    32'(e_irw));
    chk({tag, ".pc_write"},   32'(pc_write),    32'(e_pcw));
    chk({tag, ".illegal_op"}, 32'(illegal_op),  32'(e_ill));
    chk({tag, ".y"},          32'(y),           32'(e_y));
    chk({tag, ".count"},      32'(instr_count), 32'(min_i(e_cnt, 65535)));
    chk({tag, ".sat_count"},  32'(s_count),     32'(min_i(e_cnt, 3)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: each opcode expands into a list of phases; the bench
  // walks the list, stalling on F until imem_ready and on M until dmem_ready.
  function automatic string steps_of(input logic [7:0] op);
    case (op)
      8'h01:   return "FDEW";
      8'h02:   return "FD";
      8'h10:   return "FDEMW";
      8'h11:   return "FDEM";
      8'h20:   return "FDE";
      default: return "FD";
    endcase
  endfunction

  function automatic bit legal_of(input logic [7:0] op);
    return (op == 8'h01) || (op == 8'h02) || (op == 8'h10) || (op == 8'h11) || (op == 8'h20);
  endfunction

  logic [7:0] m_ir;
  string      m_prog;
  int         m_k;
  int         m_cnt;

  initial begin
    vec_t tbl[$];
    logic [7:0] ops[5] = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h20};

    rst_n = 1'b1; opcode = 8'h00; imem_ready = 1'b0; dmem_ready = 1'b0;

    // ---------------- reset with random inputs ----------------
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opcode = 8'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      #1;
      chk("rst.y",        32'(y),           32'h0);
      chk("rst.dmem_req", 32'(dmem_req),    32'h0);
      chk("rst.pc_write", 32'(pc_write),    32'h0);
      chk("rst.count",    32'(instr_count), 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("rel.imem_req", 32'(imem_req), 32'h1);

    // ---------------- directed table ----------------
    // R-type 01
    tbl.push_back(mk(8'h01, 1, 0, 1, 0, 1, 0, 0, '0, 0));
    tbl.push_back(mk(8'hAA, 1, 1, 0, 0, 0, 0, 0, '0, 0));
    tbl.push_back(mk(8'hAA, 1, 1, 0, 0, 0, 0, 0, mky(0, 0, 0, 0, 8'h01, 0, 0, 0), 0));
    tbl.push_back(mk(8'hAA, 1, 1, 0, 0, 0, 1, 0, mky(1, 0, 0, 0, 8'h00, 0, 0, 1), 0));
    // BEQ 20
    tbl.push_back(mk(8'h20, 1, 0, 1, 0, 1, 0, 0, '0, 1));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, '0, 1));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 1, 0, mky(0, 1, 0, 0, 8'h02, 0, 0, 0), 1));
    // Illegal 7F, one fetch wait cycle first
    tbl.push_back(mk(8'h7F, 0, 1, 1, 0, 0, 0, 0, '0, 2));
    tbl.push_back(mk(8'h7F, 1, 0, 1, 0, 1, 0, 0, '0, 2));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 1, '0, 2));
    // LOAD 10 with dmem_ready three cycles late
    tbl.push_back(mk(8'h10, 1, 0, 1, 0, 1, 0, 0, '0, 2));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, '0, 2));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, mky(0, 0, 0, 0, 8'h01, 0, 1, 0), 2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(8'hAA, 1, 0, 0, 1, 0, 0, 0, mky(0, 0, 1, 0, 8'h01, 0, 1, 0), 2));
    tbl.push_back(mk(8'hAA, 0, 1, 0, 1, 0, 0, 0, mky(0, 0, 1, 0, 8'h01, 0, 1, 0), 2));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 1, 0, mky(0, 0, 0, 1, 8'h00, 0, 0, 1), 2));
    // STORE 11, dmem_ready ignored in FETCH
    tbl.push_back(mk(8'h11, 0, 1, 1, 0, 0, 0, 0, '0, 3));
    tbl.push_back(mk(8'h11, 1, 0, 1, 0, 1, 0, 0, '0, 3));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, '0, 3));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 0, 0, mky(0, 0, 0, 0, 8'h01, 0, 1, 0), 3));
    tbl.push_back(mk(8'hAA, 1, 1, 0, 1, 0, 1, 0, mky(0, 0, 0, 0, 8'h01, 1, 1, 0), 3));
    // NOP 02
    tbl.push_back(mk(8'h02, 1, 0, 1, 0, 1, 0, 0, '0, 4));
    tbl.push_back(mk(8'hAA, 0, 0, 0, 0, 0, 1, 0, '0, 4));
    tbl.push_back(mk(8'hAA, 0, 0, 1, 0, 0, 0, 0, '0, 5));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      opcode = tbl[i].op; imem_ready = tbl[i].ir_rdy; dmem_ready = tbl[i].dm_rdy;
      #1;
      check_all($sformatf("tbl[%0d]", i), tbl[i].e_ireq, tbl[i].e_dreq, tbl[i].e_irw,
                tbl[i].e_pcw, tbl[i].e_ill, tbl[i].e_y, tbl[i].e_cnt);
    end

    // ---------------- 5 NOPs: 2-bit counter saturates at 3 ----------------
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); opcode = 8'h02; imem_ready = 1'b1;
      @(negedge clk); imem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("nop%0d.count", n),     32'(instr_count), 32'(n));
      chk($sformatf("nop%0d.sat_count", n), 32'(s_count),     32'(min_i(n, 3)));
    end

    // ---------------- reset during MEM of a STORE ----------------
    opcode = 8'h11; imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;          // DECODE
    @(negedge clk);                             // EXEC
    @(negedge clk); dmem_ready = 1'b0;          // MEM, waiting
    #1;
    chk("abort.mem_write_before", 32'(y[2]),     32'h1);
    chk("abort.dmem_req_before",  32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort.y",         32'(y),           32'h0);
    chk("abort.pc_write",  32'(pc_write),    32'h0);
    chk("abort.count",     32'(instr_count), 32'h0);
    chk("abort.sat_count", 32'(s_count),     32'h0);
    @(negedge clk);
    rst_n = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("abort.refetch",   32'(imem_req),    32'h1);
    chk("abort.y_after",   32'(y),           32'h0);
    chk("abort.pcw_after", 32'(pc_write),    32'h0);

    // ---------------- randomized run vs. step-list model ----------------
    do_reset();
    m_ir = '0; m_prog = ""; m_k = 0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      byte ch;
      bit legal, last, done;
      logic [7:0] aop;
      bit rd, br, mr, m2r, mw, as_, rw;
      bit e_ireq, e_dreq, e_irw, e_pcw, e_ill;
      bit rst;

      @(negedge clk);
      rst = ($urandom_range(0, 199) != 0);
      rst_n = rst;
      opcode = ($urandom_range(0, 5) == 0) ? 8'($urandom) : ops[$urandom_range(0, 4)];
      imem_ready = ($urandom_range(0, 9) < 6);
      dmem_ready = 1'($urandom);
      #1;

      if (!rst) begin
        chk("rnd.rst.y",        32'(y),           32'h0);
        chk("rnd.rst.pc_write", 32'(pc_write),    32'h0);
        chk("rnd.rst.count",    32'(instr_count), 32'h0);
        m_ir = '0; m_prog = ""; m_k = 0; m_cnt = 0;
      end else begin
        ch    = (m_k == 0) ? "F" : m_prog[m_k];
        legal = legal_of(m_ir);
        last  = (m_k == m_prog.len() - 1);
        done  = (ch == "F") ? imem_ready : (ch == "M") ? dmem_ready : 1'b1;

        aop = 8'h00; rd = 0; br = 0; mr = 0; m2r = 0; mw = 0; as_ = 0; rw = 0;
        if (ch == "E") begin
          if (m_ir == 8'h01) aop = m_ir;
          else if (m_ir == 8'h10 || m_ir == 8'h11) begin aop = 8'h01; as_ = 1; end
          else if (m_ir == 8'h20) begin aop = 8'h02; br = 1; end
        end else if (ch == "M") begin
          aop = 8'h01; as_ = 1; mr = (m_ir == 8'h10); mw = (m_ir == 8'h11);
        end else if (ch == "W") begin
          rw = 1; rd = (m_ir == 8'h01); m2r = (m_ir == 8'h10);
        end

        e_ireq = (ch == "F");
        e_irw  = (ch == "F") && imem_ready;
        e_dreq = (ch == "M");
        e_ill  = (ch == "D") && !legal;
        e_pcw  = (ch != "F") && legal && last && done;

        check_all("rnd", e_ireq, e_dreq, e_irw, e_pcw, e_ill,
                  mky(rd, br, mr, m2r, aop, mw, as_, rw), m_cnt);

        if (done) begin
          if (ch == "F") begin
            m_ir = opcode; m_prog = steps_of(opcode); m_k = 1;
          end else if (last) begin
            if (legal) m_cnt++;
            m_k = 0;
          end else begin
            m_k++;
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
